// File: rtl/mod_arith_pkg.sv
// Shared widths, coefficient type and sequencer states for the modular arithmetic blocks.
package mod_arith_pkg;

    localparam int COEF_W = 23;
    localparam int OPW_W  = 24;

    typedef logic [COEF_W-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } ctrl_state_e;

endpackage

// File: rtl/mod_add.sv
// Combinational modular adder: c = (a + b) mod q, valid when a < q and b < q.
module mod_add
    import mod_arith_pkg::*;
(
    input  logic [OPW_W-1:0] a_i,
    input  logic [OPW_W-1:0] b_i,
    input  coef_t            q_i,
    output coef_t            c_o
);

    logic [OPW_W:0] sumFull;
    logic [OPW_W:0] sumReduced;
    logic [OPW_W:0] qExt;
    logic           unusedBits;

    assign qExt       = (OPW_W+1)'(q_i);
    assign sumFull    = (OPW_W+1)'(a_i) + (OPW_W+1)'(b_i);
    assign sumReduced = sumFull - qExt;

    // With both operands below q the sum is below 2q, so one subtraction suffices.
    assign c_o = (sumFull >= qExt) ? sumReduced[COEF_W-1:0] : sumFull[COEF_W-1:0];

    assign unusedBits = ^{sumFull[OPW_W:COEF_W], sumReduced[OPW_W:COEF_W]};

endmodule

// File: rtl/mod_add_ctrl.sv
// Sequencer for coefficient-wise modular add of memories A and B into C.
// Optional macro MOD_SUB_EN: op_i=1 latched at start selects (a - b) mod q.
module mod_add_ctrl #(
    parameter int N_COEF = 256,
    parameter int ADDR_W = 8,
    parameter int COEF_W = 23
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [COEF_W-1:0] q_i,
    input  logic              op_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [COEF_W-1:0] a_data_i,
    input  logic [COEF_W-1:0] b_data_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [COEF_W-1:0] wr_data_o
);

    import mod_arith_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COEF - 1);

    ctrl_state_e       state_q, state_d;
    logic [COEF_W-1:0] modQ_q, modQ_d;
    logic              op_q, op_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rdEn_q, rdEn_d;
    logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
    logic              rdVld_q, rdVld_d;
    logic [ADDR_W-1:0] rdAddrPipe_q, rdAddrPipe_d;
    logic              wrEn_q, wrEn_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [COEF_W-1:0] wrData_q, wrData_d;

    logic [COEF_W-1:0] operandB;
    logic [OPW_W-1:0]  addA;
    logic [OPW_W-1:0]  addB;
    logic [COEF_W-1:0] addC;

`ifdef MOD_SUB_EN
    // Subtraction reuses the adder by presenting the additive inverse of b.
    always_comb begin
        operandB = b_data_i;
        if (op_q && (b_data_i != '0)) begin
            operandB = modQ_q - b_data_i;
        end
    end
`else
    logic unusedOp;

    assign operandB = b_data_i;
    assign unusedOp = op_q;
`endif

    assign addA = OPW_W'(a_data_i);
    assign addB = OPW_W'(operandB);

    mod_add u_mod_add (
        .a_i (addA),
        .b_i (addB),
        .q_i (modQ_q),
        .c_o (addC)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            modQ_q       <= '0;
            op_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rdEn_q       <= 1'b0;
            rdAddr_q     <= '0;
            rdVld_q      <= 1'b0;
            rdAddrPipe_q <= '0;
            wrEn_q       <= 1'b0;
            wrAddr_q     <= '0;
            wrData_q     <= '0;
        end else begin
            state_q      <= state_d;
            modQ_q       <= modQ_d;
            op_q         <= op_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdEn_q       <= rdEn_d;
            rdAddr_q     <= rdAddr_d;
            rdVld_q      <= rdVld_d;
            rdAddrPipe_q <= rdAddrPipe_d;
            wrEn_q       <= wrEn_d;
            wrAddr_q     <= wrAddr_d;
            wrData_q     <= wrData_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        modQ_d       = modQ_q;
        op_d         = op_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        rdEn_d       = 1'b0;
        rdAddr_d     = rdAddr_q;
        rdVld_d      = rdEn_q;
        rdAddrPipe_d = rdAddr_q;
        wrEn_d       = rdVld_q;
        wrAddr_d     = wrAddr_q;
        wrData_d     = wrData_q;

        // Memory data for the address issued last cycle is present now.
        if (rdVld_q) begin
            wrAddr_d = rdAddrPipe_q;
            wrData_d = addC;
        end

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (q_i != '0) begin
                        state_d  = RUN;
                        modQ_d   = q_i;
                        op_d     = op_i;
                        busy_d   = 1'b1;
                        rdEn_d   = 1'b1;
                        rdAddr_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (rdAddr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    rdEn_d   = 1'b1;
                    rdAddr_d = rdAddr_q + 1'b1;
                end
            end
            DRAIN: begin
                // First drain cycle still has a read in flight; the second does not.
                if (rdVld_q) begin
                    busy_d = 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign rd_en_o   = rdEn_q;
    assign rd_addr_o = rdAddr_q;
    assign wr_en_o   = wrEn_q;
    assign wr_addr_o = wrAddr_q;
    assign wr_data_o = wrData_q;

endmodule

// File: tb/tb_mod_add_ctrl.sv
// Directed bench for mod_add_ctrl: a 4-coefficient and a 256-coefficient instance with memory models.
module tb_mod_add_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        s4, op4;
    logic [22:0] q4;
    logic        busy4, done4, err4, rden4, wren4;
    logic [1:0]  rdaddr4, wraddr4;
    logic [22:0] a4, b4, wrdata4;

    logic        s256, op256;
    logic [22:0] q256;
    logic        busy256, done256, err256, rden256, wren256;
    logic [7:0]  rdaddr256, wraddr256;
    logic [22:0] a256, b256, wrdata256;

    logic [22:0] memA4 [4];
    logic [22:0] memB4 [4];
    logic [22:0] memA256 [256];
    logic [22:0] memB256 [256];
    logic [22:0] memC256 [256];
    int          wrCnt256;

    int vectors;
    int errors;

    mod_add_ctrl #(.N_COEF(4), .ADDR_W(2), .COEF_W(23)) dut4 (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (s4),
        .q_i       (q4),
        .op_i      (op4),
        .busy_o    (busy4),
        .done_o    (done4),
        .err_o     (err4),
        .rd_en_o   (rden4),
        .rd_addr_o (rdaddr4),
        .a_data_i  (a4),
        .b_data_i  (b4),
        .wr_en_o   (wren4),
        .wr_addr_o (wraddr4),
        .wr_data_o (wrdata4)
    );

    mod_add_ctrl #(.N_COEF(256), .ADDR_W(8), .COEF_W(23)) dut256 (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (s256),
        .q_i       (q256),
        .op_i      (op256),
        .busy_o    (busy256),
        .done_o    (done256),
        .err_o     (err256),
        .rd_en_o   (rden256),
        .rd_addr_o (rdaddr256),
        .a_data_i  (a256),
        .b_data_i  (b256),
        .wr_en_o   (wren256),
        .wr_addr_o (wraddr256),
        .wr_data_o (wrdata256)
    );

    // Synchronous read memories: data appears the cycle after the read enable.
    always @(posedge clk) begin
        if (rden4) begin
            a4 <= memA4[rdaddr4];
            b4 <= memB4[rdaddr4];
        end
        if (rden256) begin
            a256 <= memA256[rdaddr256];
            b256 <= memB256[rdaddr256];
        end
    end

    always @(negedge clk) begin
        if (wren256) begin
            memC256[wraddr256] = wrdata256;
            wrCnt256 = wrCnt256 + 1;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy4, done4, err4, rden4, rdaddr4, wren4, wraddr4, wrdata4} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_dut4: got %b expected all zero",
                     {busy4, done4, err4, rden4, rdaddr4, wren4, wraddr4, wrdata4});
        end
        vectors++;
        if ({busy256, done256, err256, rden256, rdaddr256, wren256, wraddr256, wrdata256} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_dut256: got %b expected all zero",
                     {busy256, done256, err256, rden256, rdaddr256, wren256, wraddr256, wrdata256});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [22:0] expC [4];
        logic        expBusy, expDone, expRd, expWr;
        expC  = '{23'd1, 23'd0, 23'd0, 23'd15};
        memA4 = '{23'd20, 23'd0, 23'd39, 23'd10};
        memB4 = '{23'd21, 23'd0, 23'd1, 23'd5};
        s4 = 1'b1;
        q4 = 23'd40;
        op4 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            s4 = 1'b0;
            expBusy = (c >= 1) && (c <= 6);
            expDone = (c == 7);
            expRd   = (c <= 4);
            expWr   = (c >= 3) && (c <= 6);
            vectors++;
            if ({busy4, done4, rden4, wren4, err4} !== {expBusy, expDone, expRd, expWr, 1'b0}) begin
                errors++;
                $display("[TB] FAIL basic_ctrl cycle %0d: got busy/done/rd/wr/err %b expected %b",
                         c, {busy4, done4, rden4, wren4, err4}, {expBusy, expDone, expRd, expWr, 1'b0});
            end
            if (expRd) begin
                vectors++;
                if (rdaddr4 !== 2'(c - 1)) begin
                    errors++;
                    $display("[TB] FAIL basic_rd_addr cycle %0d: got %0d expected %0d", c, rdaddr4, c - 1);
                end
            end
            if (expWr) begin
                vectors++;
                if ({wraddr4, wrdata4} !== {2'(c - 3), expC[c - 3]}) begin
                    errors++;
                    $display("[TB] FAIL basic_write cycle %0d: got addr %0d data %0d expected addr %0d data %0d",
                             c, wraddr4, wrdata4, c - 3, expC[c - 3]);
                end
            end
            if (c >= 7) begin
                vectors++;
                if ({rdaddr4, wraddr4, wrdata4} !== {2'd3, 2'd3, 23'd15}) begin
                    errors++;
                    $display("[TB] FAIL basic_hold cycle %0d: got rd %0d wr %0d data %0d expected 3 3 15",
                             c, rdaddr4, wraddr4, wrdata4);
                end
            end
        end
    endtask

    task automatic test_error();
        s4 = 1'b1;
        q4 = 23'd0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            s4 = 1'b0;
            vectors++;
            if ({err4, busy4, rden4, wren4, done4} !== {(c == 1), 4'b0000}) begin
                errors++;
                $display("[TB] FAIL error_path cycle %0d: got err/busy/rd/wr/done %b expected %b",
                         c, {err4, busy4, rden4, wren4, done4}, {(c == 1), 4'b0000});
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [22:0] expC [4];
        int          doneCnt;
        int          wrCnt;
        expC  = '{23'd1, 23'd0, 23'd0, 23'd15};
        memA4 = '{23'd20, 23'd0, 23'd39, 23'd10};
        memB4 = '{23'd21, 23'd0, 23'd1, 23'd5};
        doneCnt = 0;
        wrCnt = 0;
        s4 = 1'b1;
        q4 = 23'd40;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            s4 = (c == 2);
            if (c == 2) q4 = 23'd7;
            if (done4) doneCnt++;
            if (wren4) begin
                wrCnt++;
                vectors++;
                if (wrdata4 !== expC[wraddr4]) begin
                    errors++;
                    $display("[TB] FAIL busy_start_data addr %0d: got %0d expected %0d",
                             wraddr4, wrdata4, expC[wraddr4]);
                end
            end
        end
        vectors++;
        if (doneCnt !== 1) begin
            errors++;
            $display("[TB] FAIL busy_start_done_count: got %0d expected 1", doneCnt);
        end
        vectors++;
        if (wrCnt !== 4) begin
            errors++;
            $display("[TB] FAIL busy_start_write_count: got %0d expected 4", wrCnt);
        end
    endtask

    task automatic test_reset_mid_run();
        int lateEvents;
        lateEvents = 0;
        memA4 = '{23'd20, 23'd0, 23'd39, 23'd10};
        memB4 = '{23'd21, 23'd0, 23'd1, 23'd5};
        s4 = 1'b1;
        q4 = 23'd40;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            s4 = 1'b0;
            if (c == 3) rst = 1'b1;
            if (c == 4) begin
                vectors++;
                if ({busy4, done4, err4, rden4, rdaddr4, wren4, wraddr4, wrdata4} !== '0) begin
                    errors++;
                    $display("[TB] FAIL reset_mid_outputs: got %b expected all zero",
                             {busy4, done4, err4, rden4, rdaddr4, wren4, wraddr4, wrdata4});
                end
                rst = 1'b0;
            end
            if (c >= 4 && (wren4 || done4 || rden4)) lateEvents++;
        end
        vectors++;
        if (lateEvents !== 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_activity: got %0d active cycles expected 0", lateEvents);
        end
    endtask

    task automatic test_large_modulus();
        int          doneCycle;
        logic        busyBeforeDone;
        logic [22:0] expVal;
        doneCycle = -1;
        busyBeforeDone = 1'b0;
        wrCnt256 = 0;
        for (int k = 0; k < 256; k++) begin
            memA256[k] = 23'd8380416;
            memB256[k] = 23'(k);
            memC256[k] = 23'h7fffff;
        end
        s256 = 1'b1;
        q256 = 23'd8380417;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            s256 = 1'b0;
            if (c == 258) busyBeforeDone = busy256;
            if (done256) begin
                doneCycle = c;
                vectors++;
                if (busy256 !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL large_busy_at_done: got %b expected 0", busy256);
                end
                break;
            end
        end
        vectors++;
        if (doneCycle !== 259) begin
            errors++;
            $display("[TB] FAIL large_done_cycle: got %0d expected 259", doneCycle);
        end
        vectors++;
        if (busyBeforeDone !== 1'b1) begin
            errors++;
            $display("[TB] FAIL large_busy_cycle258: got %b expected 1", busyBeforeDone);
        end
        vectors++;
        if (wrCnt256 !== 256) begin
            errors++;
            $display("[TB] FAIL large_write_count: got %0d expected 256", wrCnt256);
        end
        for (int k = 0; k < 256; k++) begin
            expVal = (k == 0) ? 23'd8380416 : 23'(k - 1);
            vectors++;
            if (memC256[k] !== expVal) begin
                errors++;
                $display("[TB] FAIL large_result C[%0d]: got %0d expected %0d", k, memC256[k], expVal);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_subtract_op();
        logic [22:0] gotC [4];
        logic [22:0] exp0;
`ifdef MOD_SUB_EN
        exp0 = 23'd37;
`else
        exp0 = 23'd13;
`endif
        gotC  = '{23'h7fffff, 23'h7fffff, 23'h7fffff, 23'h7fffff};
        memA4 = '{23'd5, 23'd0, 23'd0, 23'd0};
        memB4 = '{23'd8, 23'd0, 23'd0, 23'd0};
        s4 = 1'b1;
        q4 = 23'd40;
        op4 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            s4 = 1'b0;
            op4 = 1'b0;
            if (wren4) gotC[wraddr4] = wrdata4;
        end
        vectors++;
        if (gotC[0] !== exp0) begin
            errors++;
            $display("[TB] FAIL op_result C[0]: got %0d expected %0d", gotC[0], exp0);
        end
        vectors++;
        if (gotC[1] !== 23'd0) begin
            errors++;
            $display("[TB] FAIL op_result C[1]: got %0d expected 0", gotC[1]);
        end
    endtask

    initial begin
        vectors  = 0;
        errors   = 0;
        wrCnt256 = 0;
        rst   = 1'b1;
        s4    = 1'b0;
        q4    = '0;
        op4   = 1'b0;
        s256  = 1'b0;
        q256  = '0;
        op256 = 1'b0;
        test_reset();
        test_basic();
        test_error();
        test_start_while_busy();
        test_reset_mid_run();
        test_basic();
        test_large_modulus();
        test_subtract_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
